// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: next-PC selection and instruction-memory request sequencing.
// Chooses among advance, hold and redirect each cycle. Tracks one outstanding
// fetch across a variable-latency memory, and flags a memory that never answers.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        if_valid_o,
  output logic        flush_o,
  output logic        imem_err_o
);

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pend_addr;
  logic [7:0]  r_tmo_cnt;
  logic        r_err;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_pend_load;
  logic        w_tmo_active;
  logic        w_tmo_clear;
  logic        w_tmo_hit;

  // The EX-stage branch is older than the ID-stage jump, so it wins the target.
  assign w_redirect = branch_i | jump_i;
  assign w_target   = branch_i ? branch_target_i : jump_target_i;

  // The watchdog runs while a request is outstanding and restarts on each
  // fresh entry into WAIT or DRAIN (WAIT->DRAIN counts as a fresh entry).
  assign w_tmo_active = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
  assign w_tmo_clear  = ((w_state_nxt == ST_WAIT) || (w_state_nxt == ST_DRAIN)) &&
                        (w_state_nxt != r_state);
  assign w_tmo_hit    = w_tmo_active &&
                        (({1'b0, r_tmo_cnt} + 9'd1) >= {1'b0, TMO_LIM});

  assign imem_err_o = r_err;

  // Next-state and all outputs, decoded combinationally from state and inputs.
  always_comb begin
    w_state_nxt = r_state;
    pc_next_o   = pc_i;
    imem_req_o  = 1'b0;
    imem_addr_o = r_pend_addr;
    if_valid_o  = 1'b0;
    flush_o     = 1'b0;
    w_pend_load = 1'b0;

    unique case (r_state)
      ST_BOOT: begin
        pc_next_o   = RESET_PC;
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_addr_o = pc_i;
        if (w_redirect) begin
          pc_next_o = w_target;
          flush_o   = 1'b1;
        end else if (!stall_i) begin
          imem_req_o  = 1'b1;
          w_pend_load = 1'b1;
          if (imem_ready_i) begin
            if_valid_o = 1'b1;
            pc_next_o  = pc_i + 32'd4;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        imem_req_o = 1'b1;
        if (w_redirect) begin
          // Redirect before the data arrives: the returning word must be dropped.
          pc_next_o   = w_target;
          flush_o     = 1'b1;
          w_state_nxt = imem_ready_i ? ST_FETCH : ST_DRAIN;
        end else if (imem_ready_i) begin
          // A stall here drops the word; the PC is held so it is refetched.
          if (!stall_i) begin
            if_valid_o = 1'b1;
            pc_next_o  = r_pend_addr + 32'd4;
          end
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        imem_req_o = 1'b1;
        if (w_redirect) begin
          pc_next_o = w_target;
          flush_o   = 1'b1;
        end
        if (imem_ready_i) begin
          w_state_nxt = ST_FETCH;
        end
      end
    endcase

    if (rst_i) begin
      w_state_nxt = ST_BOOT;
      pc_next_o   = RESET_PC;
      imem_req_o  = 1'b0;
      if_valid_o  = 1'b0;
      flush_o     = 1'b0;
      w_pend_load = 1'b0;
    end
  end

  // State, pending fetch address, watchdog counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_BOOT;
      r_pend_addr <= RESET_PC;
      r_tmo_cnt   <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pend_load) begin
        r_pend_addr <= pc_i;
      end
      if (w_tmo_clear) begin
        r_tmo_cnt <= 8'd0;
      end else if (w_tmo_active && (r_tmo_cnt != 8'hFF)) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
      if (w_tmo_hit) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        ready;
  logic        stall;
  logic        br;
  logic [31:0] bt;
  logic        jp;
  logic [31:0] jt;
  logic        if_valid_o;
  logic        flush_o;
  logic        imem_err_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: one outstanding fetch, optionally marked for discard.
  bit          m_boot = 1'b1;
  bit          m_busy = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_err  = 1'b0;
  logic [31:0] m_pend = RPC;
  int          m_wait = 0;

  always #5 clk = ~clk;

  // Program counter register fed by the DUT.
  always_ff @(posedge clk) pc <= pc_next_o;

  pc_fetch_ctrl #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pc_i           (pc),
    .pc_next_o      (pc_next_o),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ready_i   (ready),
    .stall_i        (stall),
    .branch_i       (br),
    .branch_target_i(bt),
    .jump_i         (jp),
    .jump_target_i  (jt),
    .if_valid_o     (if_valid_o),
    .flush_o        (flush_o),
    .imem_err_o     (imem_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare DUT outputs with the model for the current inputs, then advance the model.
  task automatic model_step();
    logic [31:0] e_pc, e_addr, tgt;
    logic        e_req, e_val, e_fl, redir;
    redir  = br | jp;
    tgt    = br ? bt : jt;
    e_pc   = pc;
    e_addr = 32'h0;
    e_req  = 1'b0;
    e_val  = 1'b0;
    e_fl   = 1'b0;
    if (rst || m_boot) begin
      e_pc = RPC;
    end else if (!m_busy) begin
      if (redir) begin
        e_pc = tgt;
        e_fl = 1'b1;
      end else if (!stall) begin
        e_req  = 1'b1;
        e_addr = pc;
        if (ready) begin
          e_val = 1'b1;
          e_pc  = pc + 32'd4;
        end
      end
    end else begin
      e_req  = 1'b1;
      e_addr = m_pend;
      if (redir) begin
        e_pc = tgt;
        e_fl = 1'b1;
      end else if (!m_drop && ready && !stall) begin
        e_val = 1'b1;
        e_pc  = m_pend + 32'd4;
      end
    end
    chk("m_pc_next", pc_next_o, e_pc);
    chk("m_req", imem_req_o, e_req);
    if (e_req) chk("m_addr", imem_addr_o, e_addr);
    chk("m_if_valid", if_valid_o, e_val);
    chk("m_flush", flush_o, e_fl);
    chk("m_err", imem_err_o, m_err);

    if (rst) begin
      m_boot = 1'b1;
      m_busy = 1'b0;
      m_drop = 1'b0;
      m_pend = RPC;
      m_wait = 0;
      m_err  = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_busy) begin
      if (!redir && !stall) begin
        m_pend = pc;
        if (!ready) begin
          m_busy = 1'b1;
          m_drop = 1'b0;
          m_wait = 0;
        end
      end
    end else begin
      if (m_wait + 1 >= TMO) m_err = 1'b1;
      if (ready) begin
        m_busy = 1'b0;
        m_drop = 1'b0;
      end else if (redir && !m_drop) begin
        m_drop = 1'b1;
        m_wait = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic stl,
                       input logic b, input logic [31:0] btg,
                       input logic j, input logic [31:0] jtg);
    rst   = r;
    ready = rdy;
    stall = stl;
    br    = b;
    bt    = btg;
    jp    = j;
    jt    = jtg;
    #4;
    model_step();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; stall = 1'b0; br = 1'b0; bt = 32'h0; jp = 1'b0; jt = 32'h0;
    tick();

    // Reset held for three cycles with ready tied high.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("rst_req", imem_req_o, 0);
      chk("rst_pc_next", pc_next_o, RPC);
      tick();
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("boot_req", imem_req_o, 0);
    chk("boot_err", imem_err_o, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("first_req", imem_req_o, 1);
    chk("first_addr", imem_addr_o, RPC);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      chk("seq_addr", imem_addr_o, RPC + 32'(4 * i));
      chk("seq_valid", if_valid_o, 1);
      tick();
    end

    // Two wait states per fetch: pc = 0x114 here.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("ws_valid_lo", if_valid_o, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("ws_addr_hold", imem_addr_o, 32'h114 + 32'(4 * k));
      tick();
      drive(0, 1, 0, 0, 0, 0, 0);
      chk("ws_valid", if_valid_o, 1);
      chk("ws_pc_next", pc_next_o, 32'h118 + 32'(4 * k));
      tick();
    end

    // Stall in FETCH for two cycles: pc = 0x120.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      chk("stall_req", imem_req_o, 0);
      chk("stall_pc_hold", pc_next_o, 32'h120);
      tick();
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("stall_resume_addr", imem_addr_o, 32'h120);
    tick();

    // Stall coincident with ready in WAIT: word dropped, same PC refetched.
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0, 0, 0, 0);
    chk("wstall_valid", if_valid_o, 0);
    chk("wstall_pc", pc_next_o, 32'h124);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("wstall_refetch", imem_addr_o, 32'h124);
    chk("wstall_refetch_valid", if_valid_o, 1);
    tick();

    // Redirect while waiting on 0x20, drained before fetching 0x40.
    drive(0, 1, 0, 0, 0, 1, 32'h20);
    chk("jmp_flush", flush_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("drn_addr0", imem_addr_o, 32'h20);
    tick();
    drive(0, 0, 0, 1, 32'h40, 0, 0);
    chk("drn_flush", flush_o, 1);
    chk("drn_pc_next", pc_next_o, 32'h40);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("drn_addr_hold", imem_addr_o, 32'h20);
      chk("drn_valid_lo", if_valid_o, 0);
      tick();
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("drn_ready_valid", if_valid_o, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("drn_next_addr", imem_addr_o, 32'h40);
    tick();

    // Branch and jump together, with a stall: branch target wins.
    drive(0, 1, 1, 1, 32'h80, 1, 32'h90);
    chk("prio_pc_next", pc_next_o, 32'h80);
    chk("prio_flush", flush_o, 1);
    tick();

    // Sequential wrap at the top of the address space.
    drive(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_pc_next", pc_next_o, 32'h0);
    tick();

    // Watchdog: memory never answers.
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int w = 1; w <= 4; w++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("wd_err_lo", imem_err_o, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wd_err_set", imem_err_o, 1);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("wd_err_sticky", imem_err_o, 1);
    tick();
    drive(1, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("wd_err_cleared", imem_err_o, 0);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      drive(logic'($urandom_range(0, 99) < 2),
            logic'($urandom_range(0, 99) < 60),
            logic'($urandom_range(0, 99) < 20),
            logic'($urandom_range(0, 99) < 8), $urandom() & 32'hFFFF_FFFC,
            logic'($urandom_range(0, 99) < 8), $urandom() & 32'hFFFF_FFFC);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
